// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared state encoding and default widths for the video capture sequencer
package video_pkg;

    localparam int C_COUNT_WIDTH_DEFAULT = 12;
    localparam int C_FRAME_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/video_sync_edge_detect.sv
// rtl/video_sync_edge_detect.sv - falling-edge detection on hsync, vsync and data enable
// Ports:
//   i_Clk, i_nRst            pixel clock, synchronous active-low reset
//   i_nHSync, i_nVSync       active-low syncs
//   i_DataEnable             active-video qualifier
//   o_HFall, o_VFall         sync assertion edges (combinational, current cycle)
//   o_DeFall                 end of an active run
module video_sync_edge_detect (
    input  logic i_Clk,
    input  logic i_nRst,
    input  logic i_nHSync,
    input  logic i_nVSync,
    input  logic i_DataEnable,
    output logic o_HFall,
    output logic o_VFall,
    output logic o_DeFall
);

    logic prev_h;
    logic prev_v;
    logic prev_de;

    // Sync copies come out of reset deasserted (high) so the first live cycle
    // only reports an edge if the sync really is asserted; DE copy starts low
    // so no end-of-line is reported before any active video was seen.
    always_ff @(posedge i_Clk) begin
        if (!i_nRst) begin
            prev_h  <= 1'b1;
            prev_v  <= 1'b1;
            prev_de <= 1'b0;
        end else begin
            prev_h  <= i_nHSync;
            prev_v  <= i_nVSync;
            prev_de <= i_DataEnable;
        end
    end

    assign o_HFall  = !i_nHSync & prev_h;
    assign o_VFall  = !i_nVSync & prev_v;
    assign o_DeFall = !i_DataEnable & prev_de;

endmodule

// File: rtl/video_capture_sequencer.sv
// rtl/video_capture_sequencer.sv - gates the video logger enable for N whole frames
// Ports:
//   i_Clk, i_nRst            pixel clock, synchronous active-low reset
//   i_Start, i_Abort         capture request / cancel
//   i_FrameCount             frames to capture, latched when a start is accepted
//   i_nHSync, i_nVSync       active-low syncs
//   i_DataEnable             active-video qualifier
//   o_OutputEnable           logger enable (CAPTURE and DE, zero latency)
//   o_PixelX, o_PixelY       active pixel / line coordinates, saturating
//   o_FrameIndex             0-based frame number within the capture
//   o_Busy                   any state other than IDLE
//   o_Done, o_Aborted        one-cycle completion / cancel pulses
module video_capture_sequencer
    import video_pkg::*;
#(
    parameter int C_COUNT_WIDTH = C_COUNT_WIDTH_DEFAULT,
    parameter int C_FRAME_WIDTH = C_FRAME_WIDTH_DEFAULT
) (
    input  logic                     i_Clk,
    input  logic                     i_nRst,
    input  logic                     i_Start,
    input  logic                     i_Abort,
    input  logic [C_FRAME_WIDTH-1:0] i_FrameCount,
    input  logic                     i_nHSync,
    input  logic                     i_nVSync,
    input  logic                     i_DataEnable,
    output logic                     o_OutputEnable,
    output logic [C_COUNT_WIDTH-1:0] o_PixelX,
    output logic [C_COUNT_WIDTH-1:0] o_PixelY,
    output logic [C_FRAME_WIDTH-1:0] o_FrameIndex,
    output logic                     o_Busy,
    output logic                     o_Done,
    output logic                     o_Aborted
);

    localparam logic [C_COUNT_WIDTH-1:0] C_COUNT_MAX = '1;

    logic h_fall;
    logic v_fall;
    logic de_fall;

    seq_state_t               state_q, state_n;
    logic [C_FRAME_WIDTH-1:0] count_q, count_n;
    logic [C_FRAME_WIDTH-1:0] frame_q, frame_n;
    logic [C_COUNT_WIDTH-1:0] x_q, x_n;
    logic [C_COUNT_WIDTH-1:0] y_q, y_n;
    logic                     done_q, done_n;
    logic                     aborted_q, aborted_n;

    video_sync_edge_detect u_edge (
        .i_Clk        (i_Clk),
        .i_nRst       (i_nRst),
        .i_nHSync     (i_nHSync),
        .i_nVSync     (i_nVSync),
        .i_DataEnable (i_DataEnable),
        .o_HFall      (h_fall),
        .o_VFall      (v_fall),
        .o_DeFall     (de_fall)
    );

    always_ff @(posedge i_Clk) begin
        if (!i_nRst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            frame_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            count_q   <= count_n;
            frame_q   <= frame_n;
            x_q       <= x_n;
            y_q       <= y_n;
            done_q    <= done_n;
            aborted_q <= aborted_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        count_n   = count_q;
        frame_n   = frame_q;
        x_n       = x_q;
        y_n       = y_q;
        done_n    = 1'b0;
        aborted_n = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A zero-length request completes immediately without arming.
                if (i_Start && !i_Abort) begin
                    if (i_FrameCount == '0) begin
                        done_n = 1'b1;
                    end else begin
                        count_n = i_FrameCount;
                        state_n = ST_ARMED;
                    end
                end
            end

            ST_ARMED: begin
                if (i_Abort) begin
                    state_n   = ST_IDLE;
                    aborted_n = 1'b1;
                end else if (v_fall) begin
                    state_n = ST_CAPTURE;
                    frame_n = '0;
                    x_n     = '0;
                    y_n     = '0;
                end
            end

            ST_CAPTURE: begin
                if (i_Abort) begin
                    state_n   = ST_IDLE;
                    aborted_n = 1'b1;
                end else if (v_fall) begin
                    // Frame boundary: either the last frame just ended or the next one starts.
                    if (frame_q == count_q - 1'b1) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        frame_n = frame_q + 1'b1;
                        x_n     = '0;
                        y_n     = '0;
                    end
                end else begin
                    if (h_fall) begin
                        x_n = '0;
                    end else if (i_DataEnable && (x_q != C_COUNT_MAX)) begin
                        x_n = x_q + 1'b1;
                    end
                    if (de_fall && (y_q != C_COUNT_MAX)) begin
                        y_n = y_q + 1'b1;
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Combinational so the enable lines up with the pixel the logger samples this cycle.
    assign o_OutputEnable = (state_q == ST_CAPTURE) & i_DataEnable;
    assign o_Busy         = (state_q != ST_IDLE);
    assign o_PixelX       = x_q;
    assign o_PixelY       = y_q;
    assign o_FrameIndex   = frame_q;
    assign o_Done         = done_q;
    assign o_Aborted      = aborted_q;

endmodule

// File: doc/video_capture_sequencer.md
Name: video_capture_sequencer

Overview:
- Controls when the simulation video logger records pixels.
- Arms on a start request, waits for the next frame boundary, then gates the logger's output enable for exactly N whole frames.
- Provides aligned pixel X/Y and frame-index coordinates, plus done/abort status.
- Sits between the video timing/colour pipeline and the logger; the logger's enable is driven only by this block.

Parameters:
- C_COUNT_WIDTH, 12, width of o_PixelX / o_PixelY counters.
- C_FRAME_WIDTH, 8, width of i_FrameCount and o_FrameIndex.

Ports:
- i_Clk  in  1  pixel clock.
- i_nRst  in  1  reset, synchronous, active-low.
- i_Start  in  1  capture request; sampled only in IDLE.
- i_Abort  in  1  cancel the capture in progress.
- i_FrameCount  in  C_FRAME_WIDTH  number of frames to capture; latched on accepted start.
- i_nHSync  in  1  horizontal sync, active-low.
- i_nVSync  in  1  vertical sync, active-low.
- i_DataEnable  in  1  active-video qualifier.
- o_OutputEnable  out  1  logger enable.
- o_PixelX  out  C_COUNT_WIDTH  active-pixel index within line.
- o_PixelY  out  C_COUNT_WIDTH  active-line index within frame.
- o_FrameIndex  out  C_FRAME_WIDTH  frame number within capture, 0-based.
- o_Busy  out  1  high in any state other than IDLE.
- o_Done  out  1  one-cycle pulse on normal completion.
- o_Aborted  out  1  one-cycle pulse on abort.

Behaviour:
- Reset (synchronous, i_nRst=0 at posedge i_Clk):
  - state=IDLE; all outputs 0; latched count=0.
  - Registered previous-sync copies are set to 1, so no false edge is detected on the first cycle after reset.
- Edge detection:
  - vfall = !i_nVSync & prevV; hfall = !i_nHSync & prevH.
  - deFall = !i_DataEnable & prevDE.
  - prev* registers update every cycle.
- States: IDLE, ARMED, CAPTURE.
  - IDLE:
    - i_Start=1 and i_Abort=0 and i_FrameCount!=0 -> latch count, go to ARMED.
    - i_Start=1 with i_FrameCount=0 -> stay IDLE, pulse o_Done next cycle.
  - ARMED:
    - i_Abort -> IDLE with o_Aborted pulse.
    - Else vfall -> CAPTURE; o_FrameIndex=0, X=0, Y=0.
  - CAPTURE:
    - i_Abort -> IDLE with o_Aborted pulse.
    - Else on vfall: if o_FrameIndex+1 == latched count -> IDLE with o_Done pulse.
    - Else on vfall (not final frame): o_FrameIndex+1, X=0, Y=0.
- Pulse timing: o_Done and o_Aborted are registered; each is high for exactly the first cycle back in IDLE.
- o_OutputEnable = (state==CAPTURE) & i_DataEnable.
  - Combinational from the registered state, so zero latency relative to the RGB/sync inputs the logger samples.
  - Never high in ARMED or IDLE, even if DE is high.
- Counters (registered, active in CAPTURE only):
  - X increments after each DE-high cycle and clears on hfall. On a cycle where o_OutputEnable=1, o_PixelX equals the index of the current pixel.
  - Y increments on deFall and clears on vfall.
  - X and Y saturate at all-ones; they do not wrap.
  - Counters hold their values in IDLE.
- Precedence: reset > abort > start/vfall.
  - Start asserted while Busy is ignored; no queuing.
  - Abort in IDLE has no effect and produces no pulse.
- Reset mid-capture: returns to IDLE immediately; no o_Done or o_Aborted pulse.
- i_FrameCount changes after the start is accepted have no effect.

Decomposition:
- Shared package video_pkg holds:
  - the state encoding constants (IDLE/ARMED/CAPTURE);
  - the default count/frame widths.
- One natural sub-module: video_sync_edge_detect, which registers nHSync/nVSync/DE and produces hfall/vfall/deFall.
- The state machine and counters live in the top level.

Test Plan:
All scenarios use a mini timing of 8 active px, 4 active lines, htotal=12, vtotal=6 lines.
- Basic capture: Start with FrameCount=2 mid-frame -> no OE until the next vfall; exactly 64 OE cycles; X 0..7 and Y 0..3 each frame; FrameIndex 0 then 1; o_Done one cycle after the 2nd following vfall; Busy low the same cycle.
- Zero frames: Start with FrameCount=0 -> never Busy, OE never high, o_Done pulses once the next cycle.
- Abort mid-capture: Abort during frame 0 line 2 -> OE low from the next cycle, o_Aborted one cycle, no o_Done; X/Y held.
- Simultaneous events:
  - Abort and vfall in the same cycle while ARMED -> IDLE, o_Aborted, never CAPTURE.
  - Start and Abort together in IDLE -> remain IDLE, no pulses.
- Reset mid-capture: i_nRst=0 for one cycle with nVSync low -> all outputs 0; after release, no spurious vfall, state IDLE.
- Saturation: C_COUNT_WIDTH=3 with 12 active px -> o_PixelX saturates at 7; clears at hfall.
